// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types for the bit-serial ALU (op codes, FSM states).
package serial_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_OR   = 3'd0,
    OP_NOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_NAND = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_bit_cell.sv
// alu_bit_cell: one-bit slice of the serial ALU, all eight ops, combinational.
module alu_bit_cell
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  output logic y,
  output logic cout
);

  logic bx;

  // SUB is A + ~B + 1: invert B here, the +1 arrives as the initial carry.
  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    bx   = b ^ (op == OP_SUB);
    case (op)
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_ADD,
      OP_SUB: begin
        y    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// serial_alu: WIDTH-bit ALU evaluated LSB first, one bit per clock.
// Optional macro SERIAL_ALU_PIPE_EN: accept a new op on the same edge a result is consumed.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] y_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             fz_q;
  logic             fc_q;
  logic             fv_q;

  logic             cell_y;
  logic             cell_cout;
  logic             is_arith;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] y_next;

  alu_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_q),
    .y    (cell_y),
    .cout (cell_cout)
  );

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign y_next   = {cell_y, y_q[WIDTH-1:1]};

`ifdef SERIAL_ALU_PIPE_EN
  assign in_ready = in_ready_q | (out_valid_q & out_ready);
`else
  assign in_ready = in_ready_q;
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flag_z    = fz_q;
  assign flag_c    = fc_q;
  assign flag_v    = fv_q;

  // Control FSM plus datapath registers. The load path is hoisted above the
  // state case because it is shared by IDLE and (with the macro) DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      y_q         <= '0;
      op_q        <= OP_OR;
      cnt         <= '0;
      carry       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fz_q        <= 1'b0;
      fc_q        <= 1'b0;
      fv_q        <= 1'b0;
    end else if (accept) begin
      a_sh        <= a;
      b_sh        <= b;
      op_q        <= op_e'(op);
      cnt         <= '0;
      carry       <= (op_e'(op) == OP_SUB);
      state       <= S_RUN;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          y_q  <= y_next;
          cnt  <= cnt + CNT_W'(1);
          if (is_arith) begin
            carry <= cell_cout;
          end
          if (last_bit) begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            fz_q        <= (y_next == '0);
            fc_q        <= is_arith & cell_cout;
            fv_q        <= is_arith & (carry ^ cell_cout);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: scoreboard bench for serial_alu with a behavioural reference model.
module tb_serial_alu;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  logic         rand_stall = 1'b0;
  logic         ready_rand = 1'b1;
  logic         ready_force = 1'b1;
  int unsigned  cyc = 0;
  int           errors = 0;
  int           checks = 0;
  res_t         exp_q[$];

  int           sw_op[6] = '{0, 1, 2, 3, 6, 7};
  logic [7:0]   sw_y[6]  = '{8'hBD, 8'h42, 8'h24, 8'hDB, 8'h99, 8'h66};

  assign out_ready = rand_stall ? ready_rand : ready_force;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ready_rand = ($urandom_range(0, 3) != 0);
  end

  // Reference: plain W-bit arithmetic, flags from operand/result signs.
  function automatic res_t model(logic [W-1:0] ma, logic [W-1:0] mb, int o);
    res_t       r;
    logic [W:0] s;
    r = '0;
    case (o)
      0: r.y = ma | mb;
      1: r.y = ~(ma | mb);
      2: r.y = ma & mb;
      3: r.y = ~(ma & mb);
      4: begin
        s   = {1'b0, ma} + {1'b0, mb};
        r.y = s[W-1:0];
        r.c = s[W];
        r.v = (ma[W-1] == mb[W-1]) && (r.y[W-1] != ma[W-1]);
      end
      5: begin
        r.y = ma - mb;
        r.c = (ma >= mb);
        r.v = (ma[W-1] != mb[W-1]) && (r.y[W-1] != ma[W-1]);
      end
      6: r.y = ma ^ mb;
      default: r.y = ~(ma ^ mb);
    endcase
    r.z = (r.y == '0);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(logic [W-1:0] ta, logic [W-1:0] tb_b, int o, res_t e,
                      output int unsigned acc);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    acc = 0;
    a = ta;
    b = tb_b;
    op = o[2:0];
    in_valid = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(e);
      acc = cyc + 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: every output handshake pops one expected result.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", {y, flag_z, flag_c, flag_v});
        end else begin
          e = exp_q.pop_front();
          chk("result", {y, flag_z, flag_c, flag_v}, e);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned t0;
    int unsigned t1;
    int          n;
    res_t        e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int          ro;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {flag_z, flag_c, flag_v}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Logic sweep against the fixed table
    for (int i = 0; i < 6; i++) begin
      e = '{y: sw_y[i], z: 1'b0, c: 1'b0, v: 1'b0};
      send(8'hA5, 8'h3C, sw_op[i], e, t0);
    end
    drain();

    // ADD wrap and result latency
    send(8'hFF, 8'h01, 4, '{y: 8'h00, z: 1'b1, c: 1'b1, v: 1'b0}, t0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    chk("add_latency", n, W);
    drain();

    // SUB corner cases
    send(8'h80, 8'h01, 5, '{y: 8'h7F, z: 1'b0, c: 1'b1, v: 1'b1}, t0);
    send(8'h01, 8'h02, 5, '{y: 8'hFF, z: 1'b0, c: 1'b0, v: 1'b0}, t0);
    drain();

    // Backpressure in DONE with a pending input
    ready_force = 1'b0;
    e = model(8'h5A, 8'h0F, 4);
    send(8'h5A, 8'h0F, 4, e, t0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    a = 8'h11;
    b = 8'h22;
    op = 3'd0;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {y, flag_z, flag_c, flag_v}, e);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    ready_force = 1'b1;
    drain();

    // Back-to-back throughput
    send(8'h03, 8'h04, 4, model(8'h03, 8'h04, 4), t0);
    send(8'h09, 8'h01, 5, model(8'h09, 8'h01, 5), t1);
`ifdef SERIAL_ALU_PIPE_EN
    chk("b2b_period", t1 - t0, W + 1);
`else
    chk("b2b_period", t1 - t0, W + 2);
`endif
    drain();

    // Reset during RUN bit 3
    send(8'h10, 8'h01, 4, model(8'h10, 8'h01, 4), t0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("no_pulse_after_reset", n, 0);
    send(8'h10, 8'h20, 4, '{y: 8'h30, z: 1'b0, c: 1'b0, v: 1'b0}, t0);
    drain();

    // Random ops with random consumer stalls
    rand_stall = 1'b1;
    repeat (1000) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ro = $urandom_range(0, 7);
      send(ra, rb, ro, model(ra, rb, ro), t0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    rand_stall = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
